// File: rtl/rv32i_dtcm_arbiter.sv
// rv32i_dtcm_arbiter: round-robin two-port DTCM arbiter with per-port 2-deep response FIFOs.
module rv32i_dtcm_arbiter #(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int MW = DW / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req_valid,
  output logic          p0_req_ready,
  input  logic [AW-1:0] p0_req_addr,
  input  logic [MW-1:0] p0_req_wen,
  input  logic [DW-1:0] p0_req_wdata,
  output logic          p0_rsp_valid,
  input  logic          p0_rsp_ready,
  output logic [DW-1:0] p0_rsp_rdata,
  input  logic          p1_req_valid,
  output logic          p1_req_ready,
  input  logic [AW-1:0] p1_req_addr,
  input  logic [MW-1:0] p1_req_wen,
  input  logic [DW-1:0] p1_req_wdata,
  output logic          p1_rsp_valid,
  input  logic          p1_rsp_ready,
  output logic [DW-1:0] p1_rsp_rdata,
  output logic [MW-1:0] ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);
  logic [1:0] req_v, rsp_r, rsp_v, elig, gnt, push;
  logic [DW-1:0] rdata [2];
  logic last_q, fl_valid_q, fl_port_q, fl_read_q;
  logic [AW-1:0] addr_q;
  assign req_v = {p1_req_valid, p0_req_valid};
  assign rsp_r = {p1_rsp_ready, p0_rsp_ready};
  // on a tie the port that did not win last time is granted
  assign gnt[0] = rst_n && req_v[0] && elig[0] && !(req_v[1] && elig[1] && !last_q);
  assign gnt[1] = rst_n && req_v[1] && elig[1] && !(req_v[0] && elig[0] && last_q);
  assign p0_req_ready = gnt[0];
  assign p1_req_ready = gnt[1];
  assign ram_wen   = gnt[0] ? p0_req_wen   : gnt[1] ? p1_req_wen   : '0;
  assign ram_wdata = gnt[0] ? p0_req_wdata : gnt[1] ? p1_req_wdata : '0;
  assign ram_addr  = gnt[0] ? p0_req_addr  : gnt[1] ? p1_req_addr  : addr_q;
  assign p0_rsp_valid = rsp_v[0];
  assign p1_rsp_valid = rsp_v[1];
  assign p0_rsp_rdata = rdata[0];
  assign p1_rsp_rdata = rdata[1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= 1'b1;
      fl_valid_q <= 1'b0;
      fl_port_q  <= 1'b0;
      fl_read_q  <= 1'b0;
      addr_q     <= '0;
    end else begin
      fl_valid_q <= |gnt;
      if (|gnt) begin
        last_q    <= gnt[1];
        fl_port_q <= gnt[1];
        fl_read_q <= ram_wen == '0;
        addr_q    <= ram_addr;
      end
    end
  end
  for (genvar i = 0; i < 2; i++) begin : g_port
    logic [1:0] cnt_q, cnt_d, out;
    logic rd_q, wr_q, pop;
    logic [DW-1:0] mem_q [2];
    assign push[i]  = fl_valid_q && (fl_port_q == 1'(i));
    assign rsp_v[i] = cnt_q != 2'd0;
    assign rdata[i] = rsp_v[i] ? mem_q[rd_q] : '0;
    assign pop      = rsp_v[i] && rsp_r[i];
    // outstanding = queued + in flight; a same-cycle pop frees a slot
    assign out      = cnt_q + {1'b0, push[i]};
    assign elig[i]  = out < 2'd2 || (out == 2'd2 && pop);
    assign cnt_d    = cnt_q + {1'b0, push[i]} - {1'b0, pop};
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q    <= 2'd0;
        rd_q     <= 1'b0;
        wr_q     <= 1'b0;
        mem_q[0] <= '0;
        mem_q[1] <= '0;
      end else begin
        cnt_q <= cnt_d;
        if (push[i]) begin
          mem_q[wr_q] <= fl_read_q ? ram_rdata : '0;
          wr_q        <= !wr_q;
        end
        if (pop) rd_q <= !rd_q;
      end
    end
  end
endmodule

// File: tb/tb_rv32i_dtcm_arbiter.sv
// tb_rv32i_dtcm_arbiter: scoreboard bench; request handshakes queue expected responses,
// a negedge monitor pops and compares data and 2-cycle latency.
module tb_rv32i_dtcm_arbiter;
  typedef struct { logic [15:0] a; logic [3:0] w; logic [31:0] d; logic [31:0] e; } req_t;
  typedef struct { logic [31:0] e; int c; bit l; } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic p0_req_valid, p0_req_ready, p0_rsp_valid, p0_rsp_ready;
  logic p1_req_valid, p1_req_ready, p1_rsp_valid, p1_rsp_ready;
  logic [15:0] p0_req_addr, p1_req_addr, ram_addr;
  logic [3:0] p0_req_wen, p1_req_wen, ram_wen;
  logic [31:0] p0_req_wdata, p1_req_wdata, p0_rsp_rdata, p1_rsp_rdata, ram_wdata, ram_rdata;
  req_t drv0[$], drv1[$];
  exp_t sb0[$], sb1[$];
  int glog[$];
  bit [1:0] lat;
  int cyc = 0, n_chk = 0, n_pass = 0;
  logic [31:0] mem [16384];

  rv32i_dtcm_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_addr(p0_req_addr),
    .p0_req_wen(p0_req_wen), .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_addr(p1_req_addr),
    .p1_req_wen(p1_req_wen), .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial for (int i = 0; i < 16384; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_wen[b]) mem[ram_addr[15:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_rdata <= mem[ram_addr[15:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic rsp(input int p, input logic [31:0] d);
    exp_t x;
    int n;
    n = (p == 0) ? sb0.size() : sb1.size();
    if (n == 0) check($sformatf("p%0d_unexpected_rsp", p), 32'(n), 1);
    else begin
      if (p == 0) x = sb0.pop_front();
      else x = sb1.pop_front();
      check($sformatf("p%0d_rdata", p), d, x.e);
      if (x.l) check($sformatf("p%0d_latency", p), 32'(cyc - x.c), 2);
    end
  endtask

  initial begin
    p0_req_valid = 0; p0_req_addr = 0; p0_req_wen = 0; p0_req_wdata = 0;
    p1_req_valid = 0; p1_req_addr = 0; p1_req_wen = 0; p1_req_wdata = 0;
    forever begin
      @(posedge clk); #1;
      p0_req_valid = drv0.size() != 0;
      if (drv0.size() != 0) begin
        p0_req_addr = drv0[0].a; p0_req_wen = drv0[0].w; p0_req_wdata = drv0[0].d;
      end
      p1_req_valid = drv1.size() != 0;
      if (drv1.size() != 0) begin
        p1_req_addr = drv1[0].a; p1_req_wen = drv1[0].w; p1_req_wdata = drv1[0].d;
      end
    end
  end

  always @(negedge clk) if (rst_n) begin
    if (p0_req_valid && p0_req_ready) begin
      sb0.push_back('{drv0[0].e, cyc, lat[0]}); void'(drv0.pop_front()); glog.push_back(0);
    end
    if (p1_req_valid && p1_req_ready) begin
      sb1.push_back('{drv1[0].e, cyc, lat[1]}); void'(drv1.pop_front()); glog.push_back(1);
    end
    if (p0_rsp_valid && p0_rsp_ready) rsp(0, p0_rsp_rdata);
    if (p1_rsp_valid && p1_rsp_ready) rsp(1, p1_rsp_rdata);
  end

  function automatic logic [31:0] glog_bits();
    logic [31:0] g = '0;
    foreach (glog[i]) if (glog[i] != 0) g[i] = 1'b1;
    return g;
  endfunction

  task automatic idle_zero(input string n);
    check({n, "_p0_req_ready"}, 32'(p0_req_ready), 0);
    check({n, "_p1_req_ready"}, 32'(p1_req_ready), 0);
    check({n, "_p0_rsp_valid"}, 32'(p0_rsp_valid), 0);
    check({n, "_p1_rsp_valid"}, 32'(p1_rsp_valid), 0);
    check({n, "_p0_rsp_rdata"}, p0_rsp_rdata, 0);
    check({n, "_p1_rsp_rdata"}, p1_rsp_rdata, 0);
    check({n, "_ram_wen"}, 32'(ram_wen), 0);
    check({n, "_ram_addr"}, 32'(ram_addr), 0);
    check({n, "_ram_wdata"}, ram_wdata, 0);
  endtask

  task automatic quiet(input string n);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check({n, "_p0_rsp_valid"}, 32'(p0_rsp_valid), 0);
      check({n, "_p1_rsp_valid"}, 32'(p1_rsp_valid), 0);
    end
  endtask

  task automatic drain(input string n);
    for (int k = 0; k < 100; k++) begin
      if (drv0.size() + drv1.size() + sb0.size() + sb1.size() == 0) break;
      @(negedge clk); #1;
    end
    check({n, "_drained"}, 32'(drv0.size() + drv1.size() + sb0.size() + sb1.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1; p0_rsp_ready = 1; p1_rsp_ready = 1; lat = 2'b11;
    #3 rst_n = 0;
    #1 idle_zero("rst");
    repeat (3) @(negedge clk);
    rst_n = 1;
    quiet("rel");
    glog.delete();
    for (int k = 0; k < 4; k++) begin
      drv0.push_back('{16'(4*k), 4'h0, 32'h0, 32'hC0DE0000 + 32'(k)});
      drv1.push_back('{16'(16'h40 + 4*k), 4'h0, 32'h0, 32'hC0DE0010 + 32'(k)});
    end
    drain("sat");
    check("sat_glog_n", 32'(glog.size()), 8);
    check("sat_glog_order", glog_bits(), 32'hAA);
    drv0.push_back('{16'h0010, 4'hF, 32'hDEADBEEF, 32'h0});
    drv0.push_back('{16'h0010, 4'h0, 32'h0, 32'hDEADBEEF});
    drain("wr_rd");
    glog.delete();
    drv1.push_back('{16'h0010, 4'b0010, 32'h0000AB00, 32'h0});
    drv0.push_back('{16'h0010, 4'h0, 32'h0, 32'hDEADABEF});
    drain("byte");
    check("byte_glog_n", 32'(glog.size()), 2);
    check("byte_glog_order", glog_bits(), 32'h1);
    glog.delete();
    p1_rsp_ready = 0; lat[1] = 0;
    for (int k = 0; k < 3; k++) drv1.push_back('{16'(16'h20 + 4*k), 4'h0, 32'h0, 32'hC0DE0008 + 32'(k)});
    repeat (4) drv0.push_back('{16'h0010, 4'h0, 32'h0, 32'hDEADABEF});
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); #1;
      if (k >= 5) check("bp_p1_req_ready", 32'(p1_req_ready), 0);
    end
    check("bp_p1_pending", 32'(drv1.size()), 1);
    check("bp_glog_n", 32'(glog.size()), 6);
    check("bp_glog_order", glog_bits(), 32'h5);
    @(posedge clk); #1;
    p1_rsp_ready = 1; lat[1] = 1;
    @(negedge clk);
    check("bp_rel_p1_req_ready", 32'(p1_req_ready), 1);
    check("bp_rel_p1_rsp_valid", 32'(p1_rsp_valid), 1);
    #1 drain("bp");
    drv0.push_back('{16'h0010, 4'h0, 32'h0, 32'hDEADABEF});
    for (int k = 0; k < 20 && drv0.size() != 0; k++) begin
      @(negedge clk); #1;
    end
    check("mid_hs", 32'(drv0.size()), 0);
    drv0.push_back('{16'h0014, 4'h0, 32'h0, 32'hC0DE0005});
    @(posedge clk); #3;
    rst_n = 0;
    #1 idle_zero("mid_rst");
    drv0.delete(); sb0.delete(); sb1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    quiet("mid_rel");
    drv0.push_back('{16'h0010, 4'h0, 32'h0, 32'hDEADABEF});
    drain("post_rst");
    check("end_pending", 32'(drv0.size() + drv1.size() + sb0.size() + sb1.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
